// File: rtl/wb_initiator.sv
// rtl/wb_initiator.sv - Wishbone classic initiator, one outstanding command/response transaction
// Optional bus-cycle timeout enabled by defining WB_INITIATOR_TIMEOUT_EN.
module wb_initiator #(
   parameter int TIMEOUT = 255
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_we,
   input  logic [31:0] cmd_adr,
   input  logic [31:0] cmd_dat,
   input  logic [3:0]  cmd_sel,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_dat,
   output logic        rsp_err,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [3:0]  wbm_sel_o,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   input  logic        wbm_ack_i,
   input  logic [31:0] wbm_dat_i
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic        cmd_ready_d;
   logic        cyc_d;
   logic        we_d;
   logic [3:0]  sel_d;
   logic [31:0] adr_d;
   logic [31:0] dat_d;
   logic        rsp_valid_d;
   logic [31:0] rsp_dat_d;

   if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
      $error("wb_initiator: TIMEOUT must be in 1..65535");
   end

`ifdef WB_INITIATOR_TIMEOUT_EN
   logic [15:0] tmo_cnt_q, tmo_cnt_d;
   logic        rsp_err_d;
   logic        bus_timeout;

   // The count reaches TIMEOUT on the edge that closes the TIMEOUT-th BUS cycle.
   assign bus_timeout = (({1'b0, tmo_cnt_q} + 17'd1) == 17'(TIMEOUT));
`else
   assign rsp_err = 1'b0;
`endif

   // Strobe always tracks cycle: classic single transfer, no bursts.
   assign wbm_stb_o = wbm_cyc_o;

   always_comb begin
      state_d     = state_q;
      cyc_d       = wbm_cyc_o;
      we_d        = wbm_we_o;
      sel_d       = wbm_sel_o;
      adr_d       = wbm_adr_o;
      dat_d       = wbm_dat_o;
      rsp_valid_d = rsp_valid;
      rsp_dat_d   = rsp_dat;
`ifdef WB_INITIATOR_TIMEOUT_EN
      tmo_cnt_d   = tmo_cnt_q;
      rsp_err_d   = rsp_err;
`endif
      case (state_q)
         IDLE: begin
            if (cmd_valid && cmd_ready) begin
               state_d = BUS;
               cyc_d   = 1'b1;
               we_d    = cmd_we;
               sel_d   = cmd_sel;
               adr_d   = cmd_adr;
               dat_d   = cmd_we ? cmd_dat : 32'h0;
`ifdef WB_INITIATOR_TIMEOUT_EN
               tmo_cnt_d = 16'h0;
`endif
            end
         end
         BUS: begin
            // Ack is checked first so an ack on the timeout cycle still completes cleanly.
            if (wbm_ack_i) begin
               state_d     = RESP;
               cyc_d       = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_dat_d   = wbm_we_o ? 32'h0 : wbm_dat_i;
`ifdef WB_INITIATOR_TIMEOUT_EN
               rsp_err_d   = 1'b0;
            end else if (bus_timeout) begin
               state_d     = RESP;
               cyc_d       = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_dat_d   = 32'h0;
               rsp_err_d   = 1'b1;
            end else begin
               tmo_cnt_d   = tmo_cnt_q + 16'd1;
`endif
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            cyc_d   = 1'b0;
         end
      endcase
      cmd_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q   <= IDLE;
         cmd_ready <= 1'b0;
         wbm_cyc_o <= 1'b0;
         wbm_we_o  <= 1'b0;
         wbm_sel_o <= 4'h0;
         wbm_adr_o <= 32'h0;
         wbm_dat_o <= 32'h0;
         rsp_valid <= 1'b0;
         rsp_dat   <= 32'h0;
      end else begin
         state_q   <= state_d;
         cmd_ready <= cmd_ready_d;
         wbm_cyc_o <= cyc_d;
         wbm_we_o  <= we_d;
         wbm_sel_o <= sel_d;
         wbm_adr_o <= adr_d;
         wbm_dat_o <= dat_d;
         rsp_valid <= rsp_valid_d;
         rsp_dat   <= rsp_dat_d;
      end
   end

`ifdef WB_INITIATOR_TIMEOUT_EN
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         tmo_cnt_q <= 16'h0;
         rsp_err   <= 1'b0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
         rsp_err   <= rsp_err_d;
      end
   end
`endif

endmodule

// File: tb/tb_wb_initiator.sv
// tb/tb_wb_initiator.sv - directed scoreboard bench for wb_initiator
// Timeout scenarios are included when WB_INITIATOR_TIMEOUT_EN is defined.
module tb_wb_initiator;

   localparam int TMO = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_we = 1'b0;
   logic [31:0] cmd_adr = 32'h0;
   logic [31:0] cmd_dat = 32'h0;
   logic [3:0]  cmd_sel = 4'h0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_dat;
   logic        rsp_err;
   logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
   logic [3:0]  wbm_sel_o;
   logic [31:0] wbm_adr_o, wbm_dat_o;
   logic        wbm_ack_i = 1'b0;
   logic [31:0] wbm_dat_i = 32'h0;

   int n_pass = 0;
   int n_total = 0;
   logic [32:0] exp_q[$];

   always #5 clk = ~clk;

   wb_initiator #(.TIMEOUT(TMO)) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_we   (cmd_we),
      .cmd_adr  (cmd_adr),
      .cmd_dat  (cmd_dat),
      .cmd_sel  (cmd_sel),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_dat  (rsp_dat),
      .rsp_err  (rsp_err),
      .wbm_cyc_o(wbm_cyc_o),
      .wbm_stb_o(wbm_stb_o),
      .wbm_we_o (wbm_we_o),
      .wbm_sel_o(wbm_sel_o),
      .wbm_adr_o(wbm_adr_o),
      .wbm_dat_o(wbm_dat_o),
      .wbm_ack_i(wbm_ack_i),
      .wbm_dat_i(wbm_dat_i)
   );

   task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // waits < 0: slave never acks. hold: cycles rsp_ready stays low with a competing command offered.
   task automatic do_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input int waits, input logic [31:0] rdata,
                         input int hold, input logic exp_err, input logic [31:0] exp_dat,
                         input int exp_stb);
      int stb_cnt;
      logic ready_low, stable;
      logic [32:0] got;
      logic [32:0] exp;
      exp_q.push_back({exp_err, exp_dat});
      check("cmd_ready_idle", {32'h0, cmd_ready}, 33'd1);
      cmd_valid = 1'b1;
      cmd_we    = we;
      cmd_adr   = adr;
      cmd_dat   = dat;
      cmd_sel   = sel;
      tick();
      cmd_valid = 1'b0;
      cmd_dat   = 32'h5555_aaaa;
      check("stb_after_accept", {31'h0, wbm_cyc_o, wbm_stb_o}, 33'd3);
      check("wbm_we", {32'h0, wbm_we_o}, {32'h0, we});
      check("wbm_adr", {1'b0, wbm_adr_o}, {1'b0, adr});
      check("wbm_sel", {29'h0, wbm_sel_o}, {29'h0, sel});
      check("wbm_dat", {1'b0, wbm_dat_o}, {1'b0, (we ? dat : 32'h0)});
      stb_cnt   = 0;
      ready_low = 1'b1;
      stable    = 1'b1;
      while (wbm_stb_o === 1'b1 && stb_cnt < 200) begin
         stb_cnt++;
         if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0) ready_low = 1'b0;
         if (wbm_adr_o !== adr || wbm_we_o !== we || wbm_sel_o !== sel) stable = 1'b0;
         wbm_ack_i = (waits >= 0 && stb_cnt == waits + 1);
         wbm_dat_i = wbm_ack_i ? rdata : 32'hdead_beef;
         tick();
      end
      wbm_ack_i = 1'b0;
      check("stb_cycles", 33'(stb_cnt), 33'(exp_stb));
      check("cmd_ready_low_in_bus", {32'h0, ready_low}, 33'd1);
      check("bus_signals_stable", {32'h0, stable}, 33'd1);
      check("rsp_valid_after_ack", {31'h0, rsp_valid, wbm_cyc_o}, 33'd2);
      // Offer another command while the response is pending; it must not be accepted.
      cmd_valid = 1'b1;
      cmd_adr   = 32'h7777_0000;
      got       = {rsp_err, rsp_dat};
      stable    = 1'b1;
      for (int i = 0; i < hold; i++) begin
         tick();
         if (rsp_valid !== 1'b1 || {rsp_err, rsp_dat} !== got || cmd_ready !== 1'b0 ||
             wbm_cyc_o !== 1'b0) stable = 1'b0;
      end
      check("rsp_hold_stable", {32'h0, stable}, 33'd1);
      rsp_ready = 1'b1;
      if (exp_q.size() == 0) begin
         check("scoreboard_empty", 33'd1, 33'd0);
      end else begin
         exp = exp_q.pop_front();
         check("rsp_dat_err", {rsp_err, rsp_dat}, exp);
      end
      tick();
      rsp_ready = 1'b0;
      cmd_valid = 1'b0;
      check("rsp_valid_drop", {31'h0, rsp_valid, wbm_cyc_o}, 33'd0);
      check("cmd_ready_back", {32'h0, cmd_ready}, 33'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic quiet;
      repeat (3) tick();
      check("reset_cmd_ready", {32'h0, cmd_ready}, 33'd0);
      check("reset_outs", {rsp_valid, rsp_err, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o},
            33'd0);
      check("reset_rsp_dat", {1'b0, rsp_dat}, 33'd0);
      check("reset_wbm_adr", {1'b0, wbm_adr_o}, 33'd0);
      check("reset_wbm_dat", {1'b0, wbm_dat_o}, 33'd0);
      rst = 1'b0;
      tick();
      check("cmd_ready_after_reset", {32'h0, cmd_ready}, 33'd1);

      // Spurious ack while idle.
      wbm_ack_i = 1'b1;
      wbm_dat_i = 32'h1234_5678;
      quiet     = 1'b1;
      repeat (3) begin
         tick();
         if (rsp_valid !== 1'b0 || wbm_cyc_o !== 1'b0 || cmd_ready !== 1'b1) quiet = 1'b0;
      end
      wbm_ack_i = 1'b0;
      check("idle_spurious_ack", {32'h0, quiet}, 33'd1);

      do_cmd(1'b1, 32'h3000_0000, 32'h0000_0001, 4'hF, 0, 32'h0, 0, 1'b0, 32'h0, 1);
      do_cmd(1'b0, 32'h3000_0004, 32'h0, 4'hF, 5, 32'h0000_0022, 0, 1'b0, 32'h0000_0022, 6);
      do_cmd(1'b0, 32'h3000_0008, 32'hffff_ffff, 4'h3, 2, 32'hcafe_f00d, 10, 1'b0,
             32'hcafe_f00d, 3);
      do_cmd(1'b1, 32'hffff_fffc, 32'ha5a5_5a5a, 4'h9, 3, 32'h1111_1111, 2, 1'b0, 32'h0, 4);

      // Reset asserted for one cycle in the middle of a bus cycle.
      cmd_valid = 1'b1;
      cmd_we    = 1'b0;
      cmd_adr   = 32'h3000_0010;
      cmd_sel   = 4'hF;
      tick();
      cmd_valid = 1'b0;
      tick();
      check("bus_before_reset", {31'h0, wbm_cyc_o, wbm_stb_o}, 33'd3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("reset_mid_bus_cyc", {31'h0, wbm_cyc_o, wbm_stb_o}, 33'd0);
      wbm_ack_i = 1'b1;
      quiet     = 1'b1;
      repeat (4) begin
         tick();
         if (rsp_valid !== 1'b0 || wbm_cyc_o !== 1'b0) quiet = 1'b0;
      end
      wbm_ack_i = 1'b0;
      check("reset_mid_bus_no_rsp", {32'h0, quiet}, 33'd1);
      do_cmd(1'b0, 32'h3000_0014, 32'h0, 4'hF, 1, 32'h0bad_cafe, 1, 1'b0, 32'h0bad_cafe, 2);

`ifdef WB_INITIATOR_TIMEOUT_EN
      do_cmd(1'b0, 32'h3000_0020, 32'h0, 4'hF, -1, 32'h0, 1, 1'b1, 32'h0, TMO);
      do_cmd(1'b0, 32'h3000_0024, 32'h0, 4'hF, TMO - 1, 32'h0000_0abc, 0, 1'b0,
             32'h0000_0abc, TMO);
      do_cmd(1'b1, 32'h3000_0028, 32'h0000_00ff, 4'h1, -1, 32'h0, 0, 1'b1, 32'h0, TMO);
`endif

      check("scoreboard_drained", 33'(exp_q.size()), 33'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
